// File: rtl/gas_alarm_if.sv
// Signal bundle between the gas detector front end, the alarm sequencer and the actuator drivers.
interface gas_alarm_if #(
    parameter int CNT_W = 8
);
    logic [2:0]       det_pulse;
    logic [2:0]       mask;
    logic             ack;
    logic             alarm;
    logic             buzzer;
    logic             fan;
    logic [2:0]       alarm_src;
    logic [1:0]       state;
    logic [CNT_W-1:0] event_cnt;

    modport master (
        output det_pulse, mask, ack,
        input  alarm, buzzer, fan, alarm_src, state, event_cnt
    );

    modport slave (
        input  det_pulse, mask, ack,
        output alarm, buzzer, fan, alarm_src, state, event_cnt
    );
endinterface

// File: rtl/gas_alarm_controller.sv
// Confirms gas detections inside a time window, latches alarm with pulsed buzzer and fan,
// and holds ventilation for a minimum period after operator acknowledge.
module gas_alarm_controller #(
    parameter int WINDOW    = 16,
    parameter int CONFIRM   = 2,
    parameter int BUZZ_HALF = 4,
    parameter int VENT_TIME = 32,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       arst,
    gas_alarm_if.slave bus
);
    localparam int WIN_W = $clog2(WINDOW + 1);
    localparam int HIT_W = $clog2(CONFIRM + 1);
    localparam int BUZ_W = $clog2(BUZZ_HALF + 1);
    localparam int VNT_W = $clog2(VENT_TIME + 1);
    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [HIT_W-1:0] HIT_LAST  = HIT_W'(CONFIRM - 1);
    localparam logic [BUZ_W-1:0] BUZ_LAST  = BUZ_W'(BUZZ_HALF - 1);
    localparam logic [VNT_W-1:0] VENT_LAST = VNT_W'(VENT_TIME - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_CONFIRM = 2'b01,
        S_ALARM   = 2'b10,
        S_VENT    = 2'b11
    } state_t;

    state_t           state_reg, state_next;
    logic [2:0]       src_reg, src_next;
    logic [CNT_W-1:0] evt_reg, evt_next;
    logic [WIN_W-1:0] win_reg, win_next;
    logic [HIT_W-1:0] hit_cnt_reg, hit_cnt_next;
    logic [BUZ_W-1:0] buzz_cnt_reg, buzz_cnt_next;
    logic [VNT_W-1:0] vent_reg, vent_next;
    logic             alarm_reg, alarm_next;
    logic             buzzer_reg, buzzer_next;
    logic             fan_reg, fan_next;
    logic             enter_alarm;
    logic [2:0]       hit_bits;
    logic             hit;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            assign hit_bits[gi] = bus.det_pulse[gi] & ~bus.mask[gi];
        end
    endgenerate
    assign hit = |hit_bits;

    always_comb begin
        state_next    = state_reg;
        src_next      = src_reg;
        evt_next      = evt_reg;
        win_next      = win_reg;
        hit_cnt_next  = hit_cnt_reg;
        buzz_cnt_next = buzz_cnt_reg;
        vent_next     = vent_reg;
        alarm_next    = 1'b0;
        buzzer_next   = 1'b0;
        fan_next      = 1'b0;
        enter_alarm   = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (hit) begin
                    src_next = hit_bits;
                    if (CONFIRM == 1) begin
                        enter_alarm = 1'b1;
                    end else begin
                        state_next   = S_CONFIRM;
                        hit_cnt_next = HIT_W'(1);
                        win_next     = '0;
                    end
                end
            end
            S_CONFIRM: begin
                win_next = win_reg + 1'b1;
                if (hit) begin
                    src_next     = src_reg | hit_bits;
                    hit_cnt_next = hit_cnt_reg + 1'b1;
                    if (hit_cnt_reg == HIT_LAST)
                        enter_alarm = 1'b1;
                end
                // A confirming hit on the last window cycle beats the timeout.
                if (!enter_alarm && win_reg == WIN_LAST) begin
                    state_next = S_IDLE;
                    src_next   = '0;
                end
            end
            S_ALARM: begin
                alarm_next = 1'b1;
                fan_next   = 1'b1;
                if (hit)
                    src_next = src_reg | hit_bits;
                if (buzz_cnt_reg == BUZ_LAST) begin
                    buzz_cnt_next = '0;
                    buzzer_next   = ~buzzer_reg;
                end else begin
                    buzz_cnt_next = buzz_cnt_reg + 1'b1;
                    buzzer_next   = buzzer_reg;
                end
                if (bus.ack) begin
                    state_next  = S_VENT;
                    vent_next   = '0;
                    alarm_next  = 1'b0;
                    buzzer_next = 1'b0;
                end
            end
            S_VENT: begin
                fan_next  = 1'b1;
                vent_next = vent_reg + 1'b1;
                if (hit) begin
                    src_next    = src_reg | hit_bits;
                    enter_alarm = 1'b1;
                end else if (vent_reg == VENT_LAST) begin
                    state_next = S_IDLE;
                    fan_next   = 1'b0;
                    src_next   = '0;
                    vent_next  = '0;
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (enter_alarm) begin
            state_next    = S_ALARM;
            alarm_next    = 1'b1;
            fan_next      = 1'b1;
            buzzer_next   = 1'b1;
            buzz_cnt_next = '0;
            vent_next     = '0;
            if (evt_reg != {CNT_W{1'b1}})
                evt_next = evt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_reg    <= S_IDLE;
            src_reg      <= '0;
            evt_reg      <= '0;
            win_reg      <= '0;
            hit_cnt_reg  <= '0;
            buzz_cnt_reg <= '0;
            vent_reg     <= '0;
            alarm_reg    <= 1'b0;
            buzzer_reg   <= 1'b0;
            fan_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            src_reg      <= src_next;
            evt_reg      <= evt_next;
            win_reg      <= win_next;
            hit_cnt_reg  <= hit_cnt_next;
            buzz_cnt_reg <= buzz_cnt_next;
            vent_reg     <= vent_next;
            alarm_reg    <= alarm_next;
            buzzer_reg   <= buzzer_next;
            fan_reg      <= fan_next;
        end
    end

    assign bus.state     = state_reg;
    assign bus.alarm     = alarm_reg;
    assign bus.buzzer    = buzzer_reg;
    assign bus.fan       = fan_reg;
    assign bus.alarm_src = src_reg;
    assign bus.event_cnt = evt_reg;
endmodule

// File: doc/gas_alarm_controller.md
Name: gas_alarm_controller

Overview:
Sequences the site alarm response from the per-gas detection pulses produced by the gas detector sensor block (bit0 methane, bit1 carbon monoxide, bit2 spare channel). It confirms detections within a time window and latches an alarm with a pulsed buzzer and ventilation fan until operator acknowledge. After acknowledge it enforces a minimum ventilation period before re-arming. It sits between the detector and the board-level actuator drivers.

Parameters:
WINDOW, 16, confirmation window length in clk cycles (>=2)
CONFIRM, 2, unmasked detection pulses required inside WINDOW to raise alarm (>=1)
BUZZ_HALF, 4, buzzer half-period in clk cycles (>=1)
VENT_TIME, 32, minimum fan run time after acknowledge, clk cycles (>=1)
CNT_W, 8, width of alarm event counter

Ports:
clk  input  1  clock, posedge
arst  input  1  reset, asynchronous, active-high
det_pulse  input  3  one-cycle detection pulses from sensor; bit0 methane, bit1 CO, bit2 spare
mask  input  3  per-channel mask; 1 = ignore that channel
ack  input  1  operator acknowledge, level sampled each cycle
alarm  output  1  alarm latched
buzzer  output  1  buzzer drive, square wave while alarm
fan  output  1  ventilation fan enable
alarm_src  output  3  sticky OR of unmasked channels that hit since leaving IDLE
state  output  2  00 IDLE, 01 CONFIRM, 10 ALARM, 11 VENT
event_cnt  output  CNT_W  number of ALARM entries, saturating

Behaviour:
- Reset: arst is asynchronous, active-high; clock clk. On arst: state=IDLE, alarm=0, buzzer=0, fan=0, alarm_src=0, event_cnt=0, all internal counters 0. All outputs registered.
- hit = |(det_pulse & ~mask); hit_bits = det_pulse & ~mask. mask applies combinationally in the same cycle.
- IDLE: outputs 0 except event_cnt. On hit: alarm_src<=hit_bits; if CONFIRM==1 go ALARM, else go CONFIRM with hit_cnt=1, win_cnt=0.
- CONFIRM: win_cnt increments every cycle; each hit ORs hit_bits into alarm_src and increments hit_cnt. When hit_cnt+1 reaches CONFIRM on a hit -> ALARM next cycle (alarm visible the cycle after the confirming pulse). If win_cnt reaches WINDOW-1 with no confirming hit that cycle -> IDLE, alarm_src cleared. A hit on the final window cycle that confirms takes priority over timeout.
- Entry to ALARM: event_cnt increments unless already all-ones; buzz_cnt=0, buzzer=1.
- ALARM: alarm=1, fan=1; buzzer toggles every BUZZ_HALF cycles; hits OR into alarm_src. ack=1 -> VENT next cycle, vent_cnt=0. ack is ignored in all other states.
- VENT: alarm=0, buzzer=0, fan=1, alarm_src held. vent_cnt increments; at VENT_TIME-1 -> IDLE, fan=0, alarm_src cleared. Any hit during VENT -> ALARM directly (no confirmation), counts as new event, vent_cnt reset. Hit wins over expiry on the same cycle.
- Simultaneous multi-bit det_pulse counts as one hit; all bits recorded in alarm_src.
- Changing mask mid-operation affects only future hits; already-recorded alarm_src bits remain.
- arst mid-operation returns immediately to reset values regardless of state.

Test Plan:
- Defaults, single det_pulse=001 then nothing for 16 cycles -> state 01 for 16 cycles, back to 00, alarm never 1, alarm_src returns to 000.
- det_pulse=001 at t0, 010 at t0+5 -> alarm=1 at t0+6, alarm_src=011, event_cnt=1, buzzer 1 for 4 cycles then 0 for 4, fan=1.
- In ALARM assert ack one cycle -> state 11, alarm=0, buzzer=0, fan=1 for exactly 32 cycles, then state 00, fan=0.
- In VENT at cycle 10 pulse det_pulse=100 -> ALARM next cycle, event_cnt=2, alarm_src includes 100; subsequent ack restarts full 32-cycle VENT.
- mask=001, repeated det_pulse=001 -> state stays 00; mask=000 then two pulses 3 cycles apart -> ALARM.
- Force 256 alarm cycles with CNT_W=8 -> event_cnt saturates at 255; arst pulse mid-ALARM -> all outputs 0 asynchronously, before next clk edge.
